// File: rtl/odd_parity_frame_ctrl_pkg.sv
// odd_parity_pkg: shared FSM state encoding and default sizing for the odd-parity frame controller
package odd_parity_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DONE = 2'd2} state_e;
  localparam int DATA_W_DEF = 4;
  localparam int FRAME_LEN_DEF = 8;
endpackage

// File: rtl/odd_parity_frame_ctrl_if.sv
// odd_parity_frame_ctrl_if: valid/ready word bus carrying a data word and its odd-parity bit
interface odd_parity_frame_ctrl_if #(parameter int DATA_W = odd_parity_pkg::DATA_W_DEF);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_par;
  modport master (output in_valid, in_data, in_par, input in_ready);
  modport slave (input in_valid, in_data, in_par, output in_ready);
endinterface

// File: rtl/odd_parity_frame_ctrl_word_chk.sv
// odd_parity_word_chk: a word is good when data plus parity hold an odd number of ones
module odd_parity_word_chk #(parameter int DATA_W = odd_parity_pkg::DATA_W_DEF) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              par_i,
  output logic              good_o
);
  assign good_o = ^{data_i, par_i};
endmodule

// File: rtl/odd_parity_frame_ctrl.sv
// odd_parity_frame_ctrl: checks odd parity across a FRAME_LEN-word frame and reports error count/first index
// ODD_PARITY_STICKY_ERR_EN adds clr_err input and err_sticky output latching any bad frame.
module odd_parity_frame_ctrl
  import odd_parity_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  localparam int IDX_W = $clog2(FRAME_LEN),
  localparam int CNT_W = $clog2(FRAME_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  odd_parity_frame_ctrl_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic                  frame_ok,
  output logic [CNT_W-1:0]      err_cnt,
`ifdef ODD_PARITY_STICKY_ERR_EN
  input  logic                  clr_err,
  output logic                  err_sticky,
`endif
  output logic [IDX_W-1:0]      first_err_idx
);
  state_e           state_q;
  logic             in_ready_q, busy_q, done_q, frame_ok_q;
  logic [IDX_W-1:0] cnt_q, first_err_q;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             good, xfer, last;

  odd_parity_word_chk #(.DATA_W(DATA_W)) u_chk (
    .data_i (bus.in_data),
    .par_i  (bus.in_par),
    .good_o (good)
  );

  assign xfer = bus.in_valid && in_ready_q;
  assign last = cnt_q == IDX_W'(FRAME_LEN - 1);
  assign err_cnt_d = err_cnt_q + CNT_W'(xfer && !good);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_ok_q  <= 1'b0;
      cnt_q       <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q     <= RECV;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b1;
          frame_ok_q  <= 1'b0;
          cnt_q       <= '0;
          err_cnt_q   <= '0;
          first_err_q <= '0;
        end
        RECV: if (xfer) begin
          cnt_q     <= cnt_q + IDX_W'(1);
          err_cnt_q <= err_cnt_d;
          if (!good && err_cnt_q == '0) first_err_q <= cnt_q;
          // frame_ok is judged on the count that already includes this final word
          if (last) begin
            state_q    <= DONE;
            in_ready_q <= 1'b0;
            done_q     <= 1'b1;
            frame_ok_q <= err_cnt_d == '0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

`ifdef ODD_PARITY_STICKY_ERR_EN
  logic err_sticky_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_sticky_q <= 1'b0;
    else if (state_q == DONE && !frame_ok_q) err_sticky_q <= 1'b1;
    else if (clr_err) err_sticky_q <= 1'b0;
  end
  assign err_sticky = err_sticky_q;
`endif

  assign bus.in_ready  = in_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign frame_ok      = frame_ok_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_err_q;
endmodule
